// File: rtl/alu_sequencer.sv
// Command-level controller for the shared 16-bit ALU: takes one {op, a, b, v} command,
// drives the load/launch/read strobe sequence and returns R1/R2/FLAGS on a response channel.
module alu_sequencer #(
    parameter int unsigned DW      = 16,
    parameter int unsigned OPW     = 6,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [OPW-1:0] cmd_op,
    input  logic [DW-1:0]  cmd_a,
    input  logic [DW-1:0]  cmd_b,
    input  logic           cmd_v,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [DW-1:0]  rsp_r1,
    output logic [DW-1:0]  rsp_r2,
    output logic [DW-1:0]  rsp_flags,
    output logic           rsp_err,
    output logic           busy,
    output logic [DW-1:0]  alu_A,
    output logic           alu_V,
    output logic [OPW-1:0] alu_op,
    output logic           alu_WA,
    output logic           alu_WB,
    output logic           alu_WD,
    output logic [1:0]     alu_WR,
    input  logic [DW-1:0]  alu_R1,
    input  logic [DW-1:0]  alu_R2,
    input  logic [DW-1:0]  alu_FLAGS,
    input  logic           alu_FINP
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LDA, S_LDB, S_EXEC, S_WAIT, S_RDSEL, S_CAPT, S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [OPW-1:0] op_q, op_d;
    logic [DW-1:0]  a_q, a_d, b_q, b_d;
    logic           v_q, v_d;

    logic           cmd_ready_q, cmd_ready_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]  rsp_r1_q, rsp_r1_d, rsp_r2_q, rsp_r2_d, rsp_flags_q, rsp_flags_d;
    logic           rsp_err_q, rsp_err_d;
    logic           busy_q, busy_d;
    logic [DW-1:0]  alu_a_q, alu_a_d;
    logic           alu_v_q, alu_v_d;
    logic [OPW-1:0] alu_op_q, alu_op_d;
    logic           alu_wa_q, alu_wa_d, alu_wb_q, alu_wb_d, alu_wd_q, alu_wd_d;
    logic [1:0]     alu_wr_q, alu_wr_d;

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        v_d         = v_q;
        rsp_r1_d    = rsp_r1_q;
        rsp_r2_d    = rsp_r2_q;
        rsp_flags_d = rsp_flags_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d   = S_LDA;
                    op_d      = cmd_op;
                    a_d       = cmd_a;
                    b_d       = cmd_b;
                    v_d       = cmd_v;
                    rsp_err_d = 1'b0;
                end
            end
            S_LDA:  state_d = S_LDB;
            S_LDB:  state_d = S_EXEC;
            S_EXEC: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (!op_q[OPW-1]) begin
                    if (cnt_q == CW'(SETTLE - 1)) state_d = S_RDSEL;
                end else if (alu_FINP) begin
                    state_d = S_RDSEL;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d     = S_RESP;
                    rsp_err_d   = 1'b1;
                    rsp_r1_d    = '0;
                    rsp_r2_d    = '0;
                    rsp_flags_d = '0;
                end
            end
            S_RDSEL: state_d = S_CAPT;
            S_CAPT: begin
                rsp_r1_d    = alu_R1;
                rsp_r2_d    = alu_R2;
                rsp_flags_d = alu_FLAGS;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        alu_wa_d    = (state_d == S_LDA);
        alu_wb_d    = (state_d == S_LDB);
        alu_wd_d    = (state_d == S_EXEC);
        alu_wr_d    = (state_d == S_RDSEL || state_d == S_CAPT) ? 2'd3 : 2'd0;
        alu_a_d     = (state_d == S_LDA) ? a_d : ((state_d == S_LDB) ? b_d : '0);
        alu_op_d    = (state_d != S_IDLE && state_d != S_RESP) ? op_d : '0;
        alu_v_d     = (state_d != S_IDLE && state_d != S_RESP) ? v_d : 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            v_q         <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_r1_q    <= '0;
            rsp_r2_q    <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            alu_a_q     <= '0;
            alu_v_q     <= 1'b0;
            alu_op_q    <= '0;
            alu_wa_q    <= 1'b0;
            alu_wb_q    <= 1'b0;
            alu_wd_q    <= 1'b0;
            alu_wr_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            v_q         <= v_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_r1_q    <= rsp_r1_d;
            rsp_r2_q    <= rsp_r2_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            alu_a_q     <= alu_a_d;
            alu_v_q     <= alu_v_d;
            alu_op_q    <= alu_op_d;
            alu_wa_q    <= alu_wa_d;
            alu_wb_q    <= alu_wb_d;
            alu_wd_q    <= alu_wd_d;
            alu_wr_q    <= alu_wr_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_r1    = rsp_r1_q;
    assign rsp_r2    = rsp_r2_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign alu_A     = alu_a_q;
    assign alu_V     = alu_v_q;
    assign alu_op    = alu_op_q;
    assign alu_WA    = alu_wa_q;
    assign alu_WB    = alu_wb_q;
    assign alu_WD    = alu_wd_q;
    assign alu_WR    = alu_wr_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU (ops 4=ADD, 5=SUB, 32=MUL, 36=DIV).
module tb_alu_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_op = '0;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic        cmd_v = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_r1, rsp_r2, rsp_flags;
    logic        rsp_err, busy;
    logic [15:0] alu_A;
    logic        alu_V;
    logic [5:0]  alu_op;
    logic        alu_WA, alu_WB, alu_WD;
    logic [1:0]  alu_WR;
    logic [15:0] alu_R1, alu_R2, alu_FLAGS;
    logic        alu_FINP;

    int checks = 0;
    int errors = 0;

    alu_sequencer dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_v(cmd_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_r1(rsp_r1), .rsp_r2(rsp_r2), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .busy(busy),
        .alu_A(alu_A), .alu_V(alu_V), .alu_op(alu_op),
        .alu_WA(alu_WA), .alu_WB(alu_WB), .alu_WD(alu_WD), .alu_WR(alu_WR),
        .alu_R1(alu_R1), .alu_R2(alu_R2), .alu_FLAGS(alu_FLAGS), .alu_FINP(alu_FINP)
    );

    always #5 CLK = ~CLK;

    // Behavioural ALU: registers A/B on strobes, launches on WD, FINP after finp_n WAIT cycles.
    logic [15:0] m_a = '0, m_b = '0;
    logic [5:0]  m_op = '0;
    logic        m_run = 1'b0;
    int          m_cnt = 0;
    int          finp_n = 0;
    logic [31:0] m_res;
    logic [15:0] m_r1, m_r2;

    always @(posedge CLK) begin
        if (RST) begin
            m_run <= 1'b0;
        end else begin
            if (alu_WA) m_a <= alu_A;
            if (alu_WB) m_b <= alu_A;
            if (alu_WD) begin
                m_op  <= alu_op;
                m_run <= 1'b1;
                m_cnt <= 1;
            end else if (m_run) begin
                m_cnt <= m_cnt + 1;
            end
            if (alu_WR == 2'd3) m_run <= 1'b0;
        end
    end

    always_comb begin
        m_res = '0;
        case (m_op)
            6'd4:  m_res = {16'h0, m_a + m_b};
            6'd5:  m_res = {16'h0, m_a - m_b};
            6'd32: m_res = m_a * m_b;
            6'd36: m_res = (m_b == 16'h0) ? 32'h0 : {m_a % m_b, m_a / m_b};
            default: m_res = '0;
        endcase
        m_r1      = m_res[15:0];
        m_r2      = m_res[31:16];
        alu_R1    = (alu_WR == 2'd3) ? m_r1 : 16'h0;
        alu_R2    = (alu_WR == 2'd3) ? m_r2 : 16'h0;
        alu_FLAGS = (alu_WR == 2'd3) ? {15'h0, (m_r1 == 16'h0)} : 16'h0;
        alu_FINP  = m_run && alu_op[5] && (finp_n > 0) && (m_cnt >= finp_n);
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Presents a command for one edge; returns in the first cycle after the accept edge.
    task automatic send(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_v = 1'b0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (3) tick();
        RST = 1'b0;
        tick();
        checks++;
        if ({cmd_ready, busy, rsp_valid, alu_WA, alu_WB, alu_WD, alu_WR, alu_V} !== 9'b100_000_00_0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=%b",
                     {cmd_ready, busy, rsp_valid, alu_WA, alu_WB, alu_WD, alu_WR, alu_V}, 9'b100000000);
        end
        checks++;
        if ({alu_A, alu_op, rsp_r1, rsp_r2, rsp_flags, rsp_err} !== 71'h0) begin
            errors++;
            $display("FAIL reset_data got A=%h op=%h r1=%h r2=%h fl=%h err=%b exp all 0",
                     alu_A, alu_op, rsp_r1, rsp_r2, rsp_flags, rsp_err);
        end
    endtask

    task automatic test_sub;
        logic [5:0]  exp_s [1:9];
        logic [15:0] exp_a [1:9];
        exp_s = '{6'b100000, 6'b010000, 6'b001000, 6'b000000, 6'b000000,
                  6'b000110, 6'b000110, 6'b000001, 6'b000000};
        exp_a = '{16'd52493, 16'd52541, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        rsp_ready = 1'b1;
        send(6'd5, 16'd52493, 16'd52541);
        for (int k = 1; k <= 9; k++) begin
            checks++;
            if ({alu_WA, alu_WB, alu_WD, alu_WR, rsp_valid} !== exp_s[k]) begin
                errors++;
                $display("FAIL sub_strobes cyc=%0d got=%b exp=%b", k,
                         {alu_WA, alu_WB, alu_WD, alu_WR, rsp_valid}, exp_s[k]);
            end
            checks++;
            if (alu_A !== exp_a[k]) begin
                errors++;
                $display("FAIL sub_alu_A cyc=%0d got=%h exp=%h", k, alu_A, exp_a[k]);
            end
            checks++;
            if (alu_op !== ((k <= 7) ? 6'd5 : 6'd0)) begin
                errors++;
                $display("FAIL sub_alu_op cyc=%0d got=%0d exp=%0d", k, alu_op, (k <= 7) ? 5 : 0);
            end
            if (k == 8) begin
                checks++;
                if ({rsp_r1, rsp_r2, rsp_flags, rsp_err, cmd_ready, busy} !== {16'hFFD0, 16'h0, 16'h0, 3'b001}) begin
                    errors++;
                    $display("FAIL sub_rsp got r1=%h r2=%h fl=%h err=%b rdy=%b busy=%b exp r1=ffd0 r2=0 fl=0 err=0 rdy=0 busy=1",
                             rsp_r1, rsp_r2, rsp_flags, rsp_err, cmd_ready, busy);
                end
            end
            if (k < 9) tick();
        end
        checks++;
        if ({cmd_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL sub_idle got rdy/busy=%b exp=10", {cmd_ready, busy});
        end
    endtask

    task automatic test_mul;
        int k;
        int wr_first;
        finp_n = 10;
        rsp_ready = 1'b1;
        send(6'b100000, 16'd300, 16'd200);
        k = 1;
        wr_first = 0;
        while (!rsp_valid && k < 100) begin
            tick();
            k++;
            if (alu_WR == 2'd3 && wr_first == 0) wr_first = k;
        end
        checks++;
        if (k != 16) begin
            errors++;
            $display("FAIL mul_latency got=%0d exp=16", k);
        end
        checks++;
        if (wr_first != 14) begin
            errors++;
            $display("FAIL mul_wr_cycle got=%0d exp=14", wr_first);
        end
        checks++;
        if ({rsp_r1, rsp_r2, rsp_flags, rsp_err} !== {16'hEA60, 16'h0, 16'h0, 1'b0}) begin
            errors++;
            $display("FAIL mul_rsp got r1=%h r2=%h fl=%h err=%b exp r1=ea60 r2=0 fl=0 err=0",
                     rsp_r1, rsp_r2, rsp_flags, rsp_err);
        end
        tick();
    endtask

    task automatic test_timeout;
        int k;
        int wr_cnt;
        finp_n = 0;
        rsp_ready = 1'b1;
        send(6'b100100, 16'd100, 16'd7);
        k = 1;
        wr_cnt = 0;
        while (!rsp_valid && k < 200) begin
            tick();
            k++;
            if (alu_WR == 2'd3) wr_cnt++;
        end
        checks++;
        if (k != 68) begin
            errors++;
            $display("FAIL timeout_latency got=%0d exp=68", k);
        end
        checks++;
        if (wr_cnt != 0) begin
            errors++;
            $display("FAIL timeout_wr_pulses got=%0d exp=0", wr_cnt);
        end
        checks++;
        if ({rsp_err, rsp_r1, rsp_r2, rsp_flags} !== {1'b1, 48'h0}) begin
            errors++;
            $display("FAIL timeout_rsp got err=%b r1=%h r2=%h fl=%h exp err=1 data 0",
                     rsp_err, rsp_r1, rsp_r2, rsp_flags);
        end
        tick();
    endtask

    task automatic test_hold;
        int k;
        rsp_ready = 1'b0;
        send(6'd5, 16'd1000, 16'd1);
        checks++;
        if (rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL hold_err_clear got=%b exp=0", rsp_err);
        end
        k = 1;
        while (!rsp_valid && k < 100) begin
            tick();
            k++;
        end
        checks++;
        if (k != 8) begin
            errors++;
            $display("FAIL hold_latency got=%0d exp=8", k);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({rsp_valid, cmd_ready, busy, rsp_r1} !== {3'b101, 16'h03E7}) begin
                errors++;
                $display("FAIL hold_stable cyc=%0d got v/rdy/busy=%b r1=%h exp 101 r1=03e7",
                         i, {rsp_valid, cmd_ready, busy}, rsp_r1);
            end
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL hold_release got v/rdy/busy=%b exp=010", {rsp_valid, cmd_ready, busy});
        end
    endtask

    task automatic test_reset_mid;
        int k;
        finp_n = 10;
        rsp_ready = 1'b1;
        send(6'b100000, 16'd300, 16'd200);
        repeat (4) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if ({alu_WA, alu_WB, alu_WD, alu_WR, cmd_ready, busy, alu_op} !== {5'b00000, 2'b10, 6'd0}) begin
            errors++;
            $display("FAIL midreset got wa/wb/wd/wr=%b rdy=%b busy=%b op=%0d exp 00000 rdy=1 busy=0 op=0",
                     {alu_WA, alu_WB, alu_WD, alu_WR}, cmd_ready, busy, alu_op);
        end
        finp_n = 0;
        send(6'd4, 16'd3, 16'd4);
        k = 1;
        while (!rsp_valid && k < 100) begin
            tick();
            k++;
        end
        checks++;
        if (k != 8 || rsp_r1 !== 16'd7) begin
            errors++;
            $display("FAIL midreset_add got lat=%0d r1=%0d exp lat=8 r1=7", k, rsp_r1);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        int wa_cyc [2];
        int rv_cyc [2];
        logic [15:0] rv_r1 [2];
        int nwa, nrv;
        nwa = 0;
        nrv = 0;
        wa_cyc = '{0, 0};
        rv_cyc = '{0, 0};
        rv_r1  = '{16'h0, 16'h0};
        rsp_ready = 1'b1;
        cmd_op = 6'd4; cmd_a = 16'd10; cmd_b = 16'd20;
        cmd_valid = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            tick();
            if (cyc == 1) begin
                cmd_a = 16'd5;
                cmd_b = 16'd6;
            end
            if (cyc == 10) cmd_valid = 1'b0;
            if (alu_WA) begin
                if (nwa < 2) wa_cyc[nwa] = cyc;
                nwa++;
            end
            if (rsp_valid) begin
                if (nrv < 2) begin
                    rv_cyc[nrv] = cyc;
                    rv_r1[nrv]  = rsp_r1;
                end
                nrv++;
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if (nwa != 2 || wa_cyc[0] != 1 || wa_cyc[1] != 10) begin
            errors++;
            $display("FAIL b2b_accepts got n=%0d at %0d,%0d exp n=2 at 1,10", nwa, wa_cyc[0], wa_cyc[1]);
        end
        checks++;
        if (nrv != 2 || rv_cyc[0] != 8 || rv_cyc[1] != 17) begin
            errors++;
            $display("FAIL b2b_rsp_cycles got n=%0d at %0d,%0d exp n=2 at 8,17", nrv, rv_cyc[0], rv_cyc[1]);
        end
        checks++;
        if (rv_r1[0] !== 16'd30 || rv_r1[1] !== 16'd11) begin
            errors++;
            $display("FAIL b2b_results got %0d,%0d exp 30,11", rv_r1[0], rv_r1[1]);
        end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_mul();
        test_timeout();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
